// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle CPU control FSM.
// Sequences fetch, decode, execute, memory and write-back. It counts retired
// instructions, and it traps on an illegal instruction class or a memory timeout.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   inst_type  decoder class (I=0 U=1 S=2 J=3 R=4 B=5; 6/7 illegal)
//   is_load    current I-type instruction is a load
//   rd         destination register index
//   ifu_ack    fetch complete this cycle
//   lsu_ack    memory access complete this cycle
//   ifu_req    fetch request (FETCH)
//   ir_we      instruction-register load (FETCH with ifu_ack)
//   lsu_req    memory request (MEM)
//   lsu_we     memory write, stores only (MEM)
//   rf_we      register-file write (WB, rd != 0)
//   pc_en      PC update / retire strobe
//   state      current FSM state
//   illegal    sticky trap flag (TRAP)
//   inst_cnt   retired instruction count
module cpu_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  inst_type,
  input  logic        is_load,
  input  logic [4:0]  rd,
  input  logic        ifu_ack,
  input  logic        lsu_ack,
  output logic        ifu_req,
  output logic        ir_we,
  output logic        lsu_req,
  output logic        lsu_we,
  output logic        rf_we,
  output logic        pc_en,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] inst_cnt
);

  localparam int unsigned ST_W  = 3;
  localparam int unsigned TMO_W = 8;
  localparam int unsigned CNT_W = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [2:0] T_I = 3'd0;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd5;

  // Last no-ack MEM cycle count value before the timeout fires.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt, tmo_d;
  logic             mem_store, store_d;

  // State, timeout counter, captured access kind and retire counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tmo_cnt   <= '0;
      mem_store <= 1'b0;
      inst_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt   <= tmo_d;
      mem_store <= store_d;
      if (pc_en) inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end

  // Next-state logic plus the two ack-dependent strobes (ir_we, pc_en).
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_cnt;
    store_d = mem_store;
    ir_we   = 1'b0;
    pc_en   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (ifu_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (inst_type > 3'd5) state_d = S_TRAP;
        else                  state_d = S_EXEC;
      end
      S_EXEC: begin
        // The access kind is captured here so MEM ignores later input changes.
        if (inst_type == T_S || (inst_type == T_I && is_load)) begin
          state_d = S_MEM;
          tmo_d   = '0;
          store_d = (inst_type == T_S);
        end else if (inst_type == T_B) begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // lsu_ack wins over a timeout firing in the same cycle.
        if (lsu_ack) begin
          if (mem_store) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          tmo_d = tmo_cnt + TMO_W'(1);
          if (tmo_cnt == TMO_LAST) state_d = S_TRAP;
        end
      end
      S_WB: begin
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Moore outputs decoded from the state register.
  assign state   = state_q;
  assign ifu_req = (state_q == S_FETCH);
  assign lsu_req = (state_q == S_MEM);
  assign lsu_we  = (state_q == S_MEM) && mem_store;
  assign rf_we   = (state_q == S_WB) && (rd != 5'd0);
  assign illegal = (state_q == S_TRAP);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Testbench for cpu_ctrl: directed per-cycle vectors with hand-computed
// expected outputs, pushed to a scoreboard queue and checked by a monitor.
module tb_cpu_ctrl;

  localparam int unsigned MEM_TIMEOUT = 15;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  // flags = {ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_en, illegal}
  localparam logic [6:0] F_NONE     = 7'b0000000;
  localparam logic [6:0] F_IFU      = 7'b1000000;
  localparam logic [6:0] F_IRW      = 7'b1100000;
  localparam logic [6:0] F_MEMRD    = 7'b0010000;
  localparam logic [6:0] F_MEMWR    = 7'b0011000;
  localparam logic [6:0] F_MEMWR_PC = 7'b0011010;
  localparam logic [6:0] F_WBRF     = 7'b0000110;
  localparam logic [6:0] F_PC       = 7'b0000010;
  localparam logic [6:0] F_TRAP     = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  inst_type;
  logic        is_load;
  logic [4:0]  rd;
  logic        ifu_ack;
  logic        lsu_ack;
  logic        ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_en, illegal;
  logic [2:0]  state;
  logic [31:0] inst_cnt;
  logic [6:0]  act_fl;

  typedef struct packed {
    logic [2:0]  st;
    logic [6:0]  fl;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  e;
  string nm;
  int    n_tests = 0;
  int    n_fail  = 0;

  cpu_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .inst_type(inst_type),
    .is_load  (is_load),
    .rd       (rd),
    .ifu_ack  (ifu_ack),
    .lsu_ack  (lsu_ack),
    .ifu_req  (ifu_req),
    .ir_we    (ir_we),
    .lsu_req  (lsu_req),
    .lsu_we   (lsu_we),
    .rf_we    (rf_we),
    .pc_en    (pc_en),
    .state    (state),
    .illegal  (illegal),
    .inst_cnt (inst_cnt)
  );

  always #5 clk = ~clk;

  assign act_fl = {ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_en, illegal};

  // Monitor: one expected record per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      if (state !== e.st || act_fl !== e.fl || inst_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: got state=%0d flags=%b cnt=%0d, want state=%0d flags=%b cnt=%0d",
                 nm, state, act_fl, inst_cnt, e.st, e.fl, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic cyc(input string n, input logic [2:0] it, input logic ld,
                     input logic [4:0] r, input logic ia, input logic la,
                     input logic [2:0] es, input logic [6:0] ef,
                     input logic [31:0] ec);
    inst_type = it;
    is_load   = ld;
    rd        = r;
    ifu_ack   = ia;
    lsu_ack   = la;
    exp_q.push_back(exp_t'({es, ef, ec}));
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; inst_type = 3'd0; is_load = 1'b0; rd = 5'd0;
    ifu_ack = 1'b0; lsu_ack = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds everything quiet even with acks asserted.
    cyc("rst_hold0", 3'd4, 1'b0, 5'd5, 1'b1, 1'b1, S_IDLE, F_NONE, 0);
    cyc("rst_hold1", 3'd2, 1'b1, 5'd5, 1'b1, 1'b1, S_IDLE, F_NONE, 0);
    rst = 1'b1;
    cyc("idle", 3'd4, 1'b0, 5'd5, 1'b0, 1'b0, S_IDLE, F_NONE, 0);

    // R-type, rd=5, immediate fetch ack.
    cyc("r_fetch",  3'd4, 1'b0, 5'd5, 1'b1, 1'b0, S_FETCH,  F_IRW,  0);
    cyc("r_decode", 3'd4, 1'b0, 5'd5, 1'b0, 1'b0, S_DECODE, F_NONE, 0);
    cyc("r_exec",   3'd4, 1'b0, 5'd5, 1'b0, 1'b0, S_EXEC,   F_NONE, 0);
    cyc("r_wb",     3'd4, 1'b0, 5'd5, 1'b0, 1'b0, S_WB,     F_WBRF, 0);

    // Store, fetch stalls once, lsu_ack on the 3rd MEM cycle; inputs change in MEM.
    cyc("st_fetch_wait", 3'd2, 1'b0, 5'd5, 1'b0, 1'b0, S_FETCH,  F_IFU,      1);
    cyc("st_fetch",      3'd2, 1'b0, 5'd5, 1'b1, 1'b0, S_FETCH,  F_IRW,      1);
    cyc("st_decode",     3'd2, 1'b0, 5'd5, 1'b0, 1'b0, S_DECODE, F_NONE,     1);
    cyc("st_exec",       3'd2, 1'b0, 5'd5, 1'b0, 1'b0, S_EXEC,   F_NONE,     1);
    cyc("st_mem1",       3'd4, 1'b0, 5'd5, 1'b0, 1'b0, S_MEM,    F_MEMWR,    1);
    cyc("st_mem2",       3'd0, 1'b1, 5'd5, 1'b0, 1'b0, S_MEM,    F_MEMWR,    1);
    cyc("st_mem3_ack",   3'd4, 1'b0, 5'd5, 1'b0, 1'b1, S_MEM,    F_MEMWR_PC, 1);

    // Branch: three cycles, retires in EXEC.
    cyc("b_fetch",  3'd5, 1'b0, 5'd5, 1'b1, 1'b0, S_FETCH,  F_IRW,  2);
    cyc("b_decode", 3'd5, 1'b0, 5'd5, 1'b0, 1'b0, S_DECODE, F_NONE, 2);
    cyc("b_exec",   3'd5, 1'b0, 5'd5, 1'b0, 1'b0, S_EXEC,   F_PC,   2);

    // R-type with rd=0: pc_en only.
    cyc("r0_fetch",  3'd4, 1'b0, 5'd0, 1'b1, 1'b0, S_FETCH,  F_IRW,  3);
    cyc("r0_decode", 3'd4, 1'b0, 5'd0, 1'b0, 1'b0, S_DECODE, F_NONE, 3);
    cyc("r0_exec",   3'd4, 1'b0, 5'd0, 1'b0, 1'b0, S_EXEC,   F_NONE, 3);
    cyc("r0_wb",     3'd4, 1'b0, 5'd0, 1'b0, 1'b0, S_WB,     F_PC,   3);

    // Load acked on the 15th MEM cycle: ack beats the timeout.
    cyc("ld_fetch",  3'd0, 1'b1, 5'd5, 1'b1, 1'b0, S_FETCH,  F_IRW,  4);
    cyc("ld_decode", 3'd0, 1'b1, 5'd5, 1'b0, 1'b0, S_DECODE, F_NONE, 4);
    cyc("ld_exec",   3'd0, 1'b1, 5'd5, 1'b0, 1'b0, S_EXEC,   F_NONE, 4);
    for (int i = 0; i < 14; i++)
      cyc("ld_mem_wait", 3'd2, 1'b0, 5'd5, 1'b0, 1'b0, S_MEM, F_MEMRD, 4);
    cyc("ld_mem15_ack", 3'd2, 1'b0, 5'd5, 1'b0, 1'b1, S_MEM, F_MEMRD, 4);
    cyc("ld_wb",        3'd2, 1'b0, 5'd5, 1'b0, 1'b0, S_WB,  F_WBRF,  4);

    // Reset dropped mid-MEM: requests vanish before the next clock edge.
    cyc("rm_fetch",  3'd0, 1'b1, 5'd5, 1'b1, 1'b0, S_FETCH,  F_IRW,   5);
    cyc("rm_decode", 3'd0, 1'b1, 5'd5, 1'b0, 1'b0, S_DECODE, F_NONE,  5);
    cyc("rm_exec",   3'd0, 1'b1, 5'd5, 1'b0, 1'b0, S_EXEC,   F_NONE,  5);
    cyc("rm_mem1",   3'd0, 1'b1, 5'd5, 1'b0, 1'b0, S_MEM,    F_MEMRD, 5);
    rst = 1'b0;
    cyc("rm_reset",  3'd0, 1'b1, 5'd5, 1'b1, 1'b1, S_IDLE,   F_NONE,  0);
    rst = 1'b1;
    cyc("rm_idle",   3'd0, 1'b0, 5'd5, 1'b0, 1'b0, S_IDLE,   F_NONE,  0);

    // Illegal class traps straight from DECODE and stays there.
    cyc("il_fetch",  3'd6, 1'b0, 5'd5, 1'b1, 1'b0, S_FETCH,  F_IRW,  0);
    cyc("il_decode", 3'd6, 1'b0, 5'd5, 1'b0, 1'b0, S_DECODE, F_NONE, 0);
    for (int i = 0; i < 4; i++)
      cyc("il_trap", 3'd4, 1'b0, 5'd5, 1'b1, 1'b1, S_TRAP, F_TRAP, 0);
    rst = 1'b0;
    cyc("trap_reset", 3'd0, 1'b1, 5'd5, 1'b0, 1'b0, S_IDLE, F_NONE, 0);
    rst = 1'b1;
    cyc("trap_idle",  3'd0, 1'b1, 5'd5, 1'b0, 1'b0, S_IDLE, F_NONE, 0);

    // Load never acked: trap after 15 MEM cycles, then absorbing for 100 cycles.
    cyc("to_fetch",  3'd0, 1'b1, 5'd5, 1'b1, 1'b0, S_FETCH,  F_IRW,  0);
    cyc("to_decode", 3'd0, 1'b1, 5'd5, 1'b0, 1'b0, S_DECODE, F_NONE, 0);
    cyc("to_exec",   3'd0, 1'b1, 5'd5, 1'b0, 1'b0, S_EXEC,   F_NONE, 0);
    for (int i = 0; i < 15; i++)
      cyc("to_mem", 3'd0, 1'b1, 5'd5, 1'b0, 1'b0, S_MEM, F_MEMRD, 0);
    for (int i = 0; i < 100; i++)
      cyc("to_trap", 3'd4, 1'b0, 5'd5, 1'b1, (i % 3) == 0, S_TRAP, F_TRAP, 0);

    // Every queued expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
